// File: rtl/uart_tool_rx.sv
// UART receiver: 1 start bit, PAYLOAD_BITS data bits LSB first, STOP_BITS stop
// bits. The asynchronous line is double-flopped and each bit is sampled at its
// midpoint. Good words, framing errors and breaks are reported as 1-cycle pulses.
module uart_tool_rx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_busy,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = 1 + $clog2(CYCLES_PER_BIT);
  localparam int BITCNT_W       = 4;

  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0]    HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [BITCNT_W-1:0] DATA_LAST = BITCNT_W'(PAYLOAD_BITS - 1);
  localparam logic [BITCNT_W-1:0] STOP_LAST = BITCNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    rxd_meta_q, rxd_s_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BITCNT_W-1:0]     bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    err_q, err_d;
  logic                    valid_q, valid_d;
  logic                    ferr_q, ferr_d;
  logic                    brk_q, brk_d;

  logic cnt_at_half, cnt_at_last, data_done, stop_done, stop_bad;

  assign cnt_at_half = (cnt_q == HALF_LAST);
  assign cnt_at_last = (cnt_q == CNT_LAST);
  assign data_done   = cnt_at_last && (bit_q == DATA_LAST);
  assign stop_done   = cnt_at_last && (bit_q == STOP_LAST);
  assign stop_bad    = err_q || !rxd_s_q;

  // Two-flop synchroniser on the raw line; idles high out of reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // State register plus all counters, shift register and registered pulses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
    end
  end

  // Next-state logic; enable only matters when deciding to leave IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!rxd_s_q && uart_rx_en) state_d = START;
      START:     if (cnt_at_half) state_d = rxd_s_q ? IDLE : DATA;
      DATA:      if (data_done) state_d = STOP;
      STOP:      if (stop_done) state_d = stop_bad ? WAIT_HIGH : IDLE;
      WAIT_HIGH: if (rxd_s_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath and pulse generation: bit timing, shifting, error tracking.
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    err_d   = err_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    brk_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        err_d = 1'b0;
      end
      START: begin
        cnt_d = cnt_at_half ? '0 : cnt_q + 1'b1;
      end
      DATA: begin
        if (cnt_at_last) begin
          cnt_d                 = '0;
          shift_d               = shift_q >> 1;
          shift_d[PAYLOAD_BITS-1] = rxd_s_q;
          bit_d                 = data_done ? '0 : bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_at_last) begin
          cnt_d = '0;
          err_d = stop_bad;
          if (stop_done) begin
            bit_d = '0;
            if (stop_bad) begin
              ferr_d = 1'b1;
              brk_d  = (shift_q == '0);
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d = '0;
        bit_d = '0;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    uart_rx_busy      = (state_q != IDLE);
    uart_rx_valid     = valid_q;
    uart_rx_data      = data_q;
    uart_rx_frame_err = ferr_q;
    uart_rx_break     = brk_q;
  end

endmodule

// File: tb/tb_uart_tool_rx.sv
// Self-checking bench for uart_tool_rx at 10 clocks per bit, 8N1.
module tb_uart_tool_rx;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       resetn;
  logic       uart_rxd;
  logic       uart_rx_en;
  logic       uart_rx_busy;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_frame_err;
  logic       uart_rx_break;

  int checks = 0;
  int failures = 0;

  // Event word: {valid, frame_err, break, data}
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  logic        busy_seen = 1'b0;

  uart_tool_rx #(
    .BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(8), .STOP_BITS(1)
  ) dut (
    .clk(clk), .resetn(resetn), .uart_rxd(uart_rxd), .uart_rx_en(uart_rx_en),
    .uart_rx_busy(uart_rx_busy), .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data), .uart_rx_frame_err(uart_rx_frame_err),
    .uart_rx_break(uart_rx_break)
  );

  always #5 clk = ~clk;

  // Capture every output pulse cycle away from the active edge.
  always @(negedge clk) begin
    if (resetn && (uart_rx_valid || uart_rx_frame_err || uart_rx_break))
      obs_q.push_back({uart_rx_valid, uart_rx_frame_err, uart_rx_break, uart_rx_data});
    if (uart_rx_busy) busy_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int drop_en_at);
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      if (i == drop_en_at) uart_rx_en = 1'b0;
      uart_rxd = d[i];
      tick(CPB);
    end
    uart_rxd = stop_v;
    tick(CPB);
  endtask

  task automatic test_reset();
    resetn = 1'b0; uart_rxd = 1'b1; uart_rx_en = 1'b1;
    tick(5);
    checks++; if (uart_rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", uart_rx_busy); end
    checks++; if (uart_rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", uart_rx_valid); end
    checks++; if (uart_rx_frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", uart_rx_frame_err); end
    checks++; if (uart_rx_break !== 1'b0) begin failures++; $display("FAIL reset_break got=%b exp=0", uart_rx_break); end
    checks++; if (uart_rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", uart_rx_data); end
    resetn = 1'b1;
    tick(20);
    obs_q.delete();
  endtask

  task automatic test_single();
    logic [10:0] e, o;
    busy_seen = 1'b0;
    exp_q.push_back({3'b100, 8'hA5});
    send_frame(8'hA5, 1'b1, -1);
    tick(20);
    checks++; if (busy_seen !== 1'b1) begin failures++; $display("FAIL single_busy_seen got=%b exp=1", busy_seen); end
    checks++; if (uart_rx_busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", uart_rx_busy); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL single_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL single_event got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [10:0] e, o;
    exp_q.push_back({3'b100, 8'h55});
    exp_q.push_back({3'b100, 8'h0F});
    send_frame(8'h55, 1'b1, -1);
    send_frame(8'h0F, 1'b1, -1);
    tick(20);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL b2b_event got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_glitch();
    uart_rxd = 1'b0;
    tick(3);
    uart_rxd = 1'b1;
    tick(30);
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", obs_q.size()); end
    checks++; if (uart_rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%b exp=0", uart_rx_busy); end
    checks++; if (uart_rx_data !== 8'h0F) begin failures++; $display("FAIL glitch_data got=%h exp=0f", uart_rx_data); end
    obs_q.delete();
  endtask

  task automatic test_break();
    logic [10:0] e, o;
    exp_q.push_back({3'b011, 8'h0F});
    exp_q.push_back({3'b100, 8'h3C});
    send_frame(8'h00, 1'b0, -1);
    tick(50);
    checks++; if (uart_rx_busy !== 1'b1) begin failures++; $display("FAIL break_hold_busy got=%b exp=1", uart_rx_busy); end
    uart_rxd = 1'b1;
    tick(20);
    checks++; if (uart_rx_busy !== 1'b0) begin failures++; $display("FAIL break_release_busy got=%b exp=0", uart_rx_busy); end
    send_frame(8'h3C, 1'b1, -1);
    tick(20);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL break_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL break_event got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_frame_err();
    logic [10:0] e, o;
    exp_q.push_back({3'b010, 8'h3C});
    send_frame(8'h81, 1'b0, -1);
    uart_rxd = 1'b1;
    tick(20);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL ferr_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL ferr_event got=%h exp=%h", o, e); end
    end
    checks++; if (uart_rx_data !== 8'h3C) begin failures++; $display("FAIL ferr_data_hold got=%h exp=3c", uart_rx_data); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] e, o;
    logic [7:0]  d;
    d = 8'h99;
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_rxd = d[i];
      tick(CPB);
    end
    resetn = 1'b0;
    uart_rxd = 1'b1;
    tick(3);
    resetn = 1'b1;
    tick(30);
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL abort_pulses got=%0d exp=0", obs_q.size()); end
    checks++; if (uart_rx_data !== 8'h00) begin failures++; $display("FAIL abort_data got=%h exp=00", uart_rx_data); end
    obs_q.delete();
    exp_q.push_back({3'b100, 8'hC3});
    send_frame(8'hC3, 1'b1, -1);
    tick(20);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL after_reset_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL after_reset_event got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_enable();
    logic [10:0] e, o;
    uart_rx_en = 1'b0;
    busy_seen = 1'b0;
    send_frame(8'h12, 1'b1, -1);
    tick(20);
    checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL en_off_busy got=%b exp=0", busy_seen); end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL en_off_pulses got=%0d exp=0", obs_q.size()); end
    checks++; if (uart_rx_data !== 8'hC3) begin failures++; $display("FAIL en_off_data got=%h exp=c3", uart_rx_data); end
    obs_q.delete();
    uart_rx_en = 1'b1;
    exp_q.push_back({3'b100, 8'h6B});
    send_frame(8'h6B, 1'b1, 2);
    tick(20);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL en_drop_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL en_drop_event got=%h exp=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    uart_rx_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_frame_err();
    test_reset_mid_frame();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
